// File: rtl/ramb_arbiter.sv
// ramb_arbiter: two-requester front end for one SB_RAM40_4K in 256x16 mode.
// Grants are combinational, with round-robin between the two requesters on
// each RAM port. A read whose address matches the granted write is held back
// one cycle. Read data is routed back to the issuing requester one cycle
// after its grant.
module ramb_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          CLKIN,
    input  logic          RESETN,
    input  logic          REQ0_VALID,
    output logic          REQ0_READY,
    input  logic          REQ0_WE,
    input  logic [AW-1:0] REQ0_ADDR,
    input  logic [DW-1:0] REQ0_WDATA,
    input  logic [DW-1:0] REQ0_MASK,
    output logic          RSP0_VALID,
    output logic [DW-1:0] RSP0_DATA,
    input  logic          REQ1_VALID,
    output logic          REQ1_READY,
    input  logic          REQ1_WE,
    input  logic [AW-1:0] REQ1_ADDR,
    input  logic [DW-1:0] REQ1_WDATA,
    input  logic [DW-1:0] REQ1_MASK,
    output logic          RSP1_VALID,
    output logic [DW-1:0] RSP1_DATA,
    output logic [AW-1:0] RAM_RADDR,
    output logic          RAM_RE,
    output logic [AW-1:0] RAM_WADDR,
    output logic [DW-1:0] RAM_WDATA,
    output logic [DW-1:0] RAM_MASK,
    output logic          RAM_WE,
    input  logic [DW-1:0] RAM_RDATA
);

    logic pri;    // requester that wins the next two-way conflict
    logic rpend;  // a read was granted last cycle
    logic rsel;   // which requester that read belongs to

    logic          wc0, wc1, rc0, rc1;
    logic          w_sel, r_sel;
    logic [AW-1:0] w_addr_sel, r_addr_sel;
    logic          hazard, w_gnt, r_gnt;

    assign wc0 = REQ0_VALID &  REQ0_WE;
    assign wc1 = REQ1_VALID &  REQ1_WE;
    assign rc0 = REQ0_VALID & ~REQ0_WE;
    assign rc1 = REQ1_VALID & ~REQ1_WE;

    // Each port picks independently; PRI breaks ties only on a two-way conflict.
    assign w_sel = (wc0 & wc1) ? pri : wc1;
    assign r_sel = (rc0 & rc1) ? pri : rc1;

    assign w_addr_sel = w_sel ? REQ1_ADDR : REQ0_ADDR;
    assign r_addr_sel = r_sel ? REQ1_ADDR : REQ0_ADDR;

    // Compare the selected addresses rather than RAM_RADDR, which is zeroed
    // when the read is vetoed. Strobes stay low throughout reset.
    assign w_gnt  = RESETN & (wc0 | wc1);
    assign hazard = w_gnt & (rc0 | rc1) & (r_addr_sel == w_addr_sel);
    assign r_gnt  = RESETN & (rc0 | rc1) & ~hazard;

    // Per-requester READY and the RAM port drive, zeroed on an idle port.
    always_comb begin
        REQ0_READY = (w_gnt & ~w_sel) | (r_gnt & ~r_sel);
        REQ1_READY = (w_gnt &  w_sel) | (r_gnt &  r_sel);
        RAM_WE     = w_gnt;
        RAM_RE     = r_gnt;
        RAM_WADDR  = '0;
        RAM_WDATA  = '0;
        RAM_MASK   = '0;
        RAM_RADDR  = '0;
        if (w_gnt) begin
            RAM_WADDR = w_addr_sel;
            RAM_WDATA = w_sel ? REQ1_WDATA : REQ0_WDATA;
            RAM_MASK  = w_sel ? REQ1_MASK  : REQ0_MASK;
        end
        if (r_gnt) begin
            RAM_RADDR = r_addr_sel;
        end
    end

    // Priority flips to the loser whenever a two-way conflict is granted.
    // Two readers imply no writer, so a read conflict is never vetoed here.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            pri <= 1'b0;
        end else if ((wc0 & wc1) | (rc0 & rc1 & r_gnt)) begin
            pri <= ~pri;
        end
    end

    // Remember who owns the read in flight so the data returns to them.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            rpend <= 1'b0;
            rsel  <= 1'b0;
        end else begin
            rpend <= r_gnt;
            rsel  <= r_sel;
        end
    end

    assign RSP0_VALID = rpend & ~rsel;
    assign RSP1_VALID = rpend &  rsel;
    assign RSP0_DATA  = RSP0_VALID ? RAM_RDATA : '0;
    assign RSP1_DATA  = RSP1_VALID ? RAM_RDATA : '0;

endmodule

// File: tb/tb_ramb_arbiter.sv
// Bench for ramb_arbiter: a behavioural SB_RAM40_4K, directed scenarios, then
// randomized traffic scored against a rule-level model of the arbiter.
module tb_ramb_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          CLKIN, RESETN;
    logic          REQ0_VALID, REQ0_READY, REQ0_WE, RSP0_VALID;
    logic [AW-1:0] REQ0_ADDR;
    logic [DW-1:0] REQ0_WDATA, REQ0_MASK, RSP0_DATA;
    logic          REQ1_VALID, REQ1_READY, REQ1_WE, RSP1_VALID;
    logic [AW-1:0] REQ1_ADDR;
    logic [DW-1:0] REQ1_WDATA, REQ1_MASK, RSP1_DATA;
    logic [AW-1:0] RAM_RADDR, RAM_WADDR;
    logic          RAM_RE, RAM_WE;
    logic [DW-1:0] RAM_WDATA, RAM_MASK, RAM_RDATA;

    int checks = 0;
    int errors = 0;

    ramb_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLKIN(CLKIN), .RESETN(RESETN),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WE(REQ0_WE),
        .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA), .REQ0_MASK(REQ0_MASK),
        .RSP0_VALID(RSP0_VALID), .RSP0_DATA(RSP0_DATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WE(REQ1_WE),
        .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA), .REQ1_MASK(REQ1_MASK),
        .RSP1_VALID(RSP1_VALID), .RSP1_DATA(RSP1_DATA),
        .RAM_RADDR(RAM_RADDR), .RAM_RE(RAM_RE), .RAM_WADDR(RAM_WADDR),
        .RAM_WDATA(RAM_WDATA), .RAM_MASK(RAM_MASK), .RAM_WE(RAM_WE),
        .RAM_RDATA(RAM_RDATA)
    );

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    // Behavioural SB_RAM40_4K, 256x16, masked write, registered read.
    logic [DW-1:0] ram [256];
    initial begin
        for (int a = 0; a < 256; a++) ram[a] = '0;
        RAM_RDATA = '0;
    end
    always @(posedge CLKIN) begin
        if (RAM_WE) ram[RAM_WADDR] <= (ram[RAM_WADDR] & RAM_MASK) | (RAM_WDATA & ~RAM_MASK);
        if (RAM_RE) RAM_RDATA <= ram[RAM_RADDR];
    end

    task automatic cyc();
        @(posedge CLKIN); #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
        REQ0_VALID = v; REQ0_WE = we; REQ0_ADDR = a; REQ0_WDATA = d; REQ0_MASK = m;
    endtask

    task automatic set1(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
        REQ1_VALID = v; REQ1_WE = we; REQ1_ADDR = a; REQ1_WDATA = d; REQ1_MASK = m;
    endtask

    task automatic idle();
        set0(0, 0, '0, '0, '0);
        set1(0, 0, '0, '0, '0);
    endtask

    task automatic do_reset();
        idle();
        RESETN = 1'b0;
        cyc();
        cyc();
        RESETN = 1'b1;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        set0(1, 0, 8'h01, '0, '0);
        set1(1, 0, 8'h02, '0, '0);
        @(negedge CLKIN);
        checks++; if ({REQ0_READY, REQ1_READY} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {REQ0_READY, REQ1_READY}); end
        checks++; if ({RAM_WE, RAM_RE} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {RAM_WE, RAM_RE}); end
        checks++; if ({RSP0_VALID, RSP1_VALID} !== 2'b00) begin errors++; $display("FAIL rst_rsp got %b exp 00", {RSP0_VALID, RSP1_VALID}); end
        cyc();
        RESETN = 1'b1;
        @(negedge CLKIN);
        checks++; if ({REQ0_READY, REQ1_READY} !== 2'b10) begin errors++; $display("FAIL rst_first_conflict got %b exp 10", {REQ0_READY, REQ1_READY}); end
        cyc();
        set0(0, 0, '0, '0, '0);
        @(negedge CLKIN);
        checks++; if ({REQ0_READY, REQ1_READY} !== 2'b01) begin errors++; $display("FAIL rst_second_grant got %b exp 01", {REQ0_READY, REQ1_READY}); end
        checks++; if ({RSP0_VALID, RSP1_VALID} !== 2'b10) begin errors++; $display("FAIL rst_rsp0 got %b exp 10", {RSP0_VALID, RSP1_VALID}); end
        cyc();
        idle();
        @(negedge CLKIN);
        checks++; if ({RSP0_VALID, RSP1_VALID} !== 2'b01) begin errors++; $display("FAIL rst_rsp1 got %b exp 01", {RSP0_VALID, RSP1_VALID}); end
        cyc();
    endtask

    task automatic test_write_read();
        set0(1, 1, 8'h12, 16'hA5A5, 16'h0000);
        @(negedge CLKIN);
        checks++; if ({REQ0_READY, RAM_WE, RAM_RE} !== 3'b110) begin errors++; $display("FAIL wr_grant got %b exp 110", {REQ0_READY, RAM_WE, RAM_RE}); end
        checks++; if (RAM_WADDR !== 8'h12) begin errors++; $display("FAIL wr_waddr got %h exp 12", RAM_WADDR); end
        cyc();
        set0(0, 0, '0, '0, '0);
        set1(1, 0, 8'h12, '0, '0);
        @(negedge CLKIN);
        checks++; if ({REQ1_READY, RAM_RE} !== 2'b11) begin errors++; $display("FAIL rd_grant got %b exp 11", {REQ1_READY, RAM_RE}); end
        checks++; if (RAM_RADDR !== 8'h12) begin errors++; $display("FAIL rd_raddr got %h exp 12", RAM_RADDR); end
        cyc();
        idle();
        @(negedge CLKIN);
        checks++; if ({RSP0_VALID, RSP1_VALID} !== 2'b01) begin errors++; $display("FAIL wr_rd_rspv got %b exp 01", {RSP0_VALID, RSP1_VALID}); end
        checks++; if (RSP1_DATA !== 16'hA5A5) begin errors++; $display("FAIL wr_rd_data got %h exp a5a5", RSP1_DATA); end
        checks++; if (RSP0_DATA !== 16'h0000) begin errors++; $display("FAIL rsp0_idle_data got %h exp 0000", RSP0_DATA); end
        cyc();
        @(negedge CLKIN);
        checks++; if ({RSP0_VALID, RSP1_VALID} !== 2'b00) begin errors++; $display("FAIL rsp_one_cycle got %b exp 00", {RSP0_VALID, RSP1_VALID}); end
        cyc();
    endtask

    task automatic test_concurrent();
        do_reset();
        set0(1, 1, 8'h03, 16'h1234, 16'h0000);
        set1(1, 0, 8'h04, '0, '0);
        @(negedge CLKIN);
        checks++; if ({REQ0_READY, REQ1_READY, RAM_WE, RAM_RE} !== 4'b1111) begin errors++; $display("FAIL conc_grants got %b exp 1111", {REQ0_READY, REQ1_READY, RAM_WE, RAM_RE}); end
        cyc();
        // PRI must still favour REQ0 on the next read conflict.
        set0(1, 0, 8'h05, '0, '0);
        set1(1, 0, 8'h06, '0, '0);
        @(negedge CLKIN);
        checks++; if ({REQ0_READY, REQ1_READY} !== 2'b10) begin errors++; $display("FAIL conc_pri got %b exp 10", {REQ0_READY, REQ1_READY}); end
        checks++; if ({RSP0_VALID, RSP1_VALID} !== 2'b01) begin errors++; $display("FAIL conc_rsp got %b exp 01", {RSP0_VALID, RSP1_VALID}); end
        cyc();
        idle();
        cyc();
        cyc();
    endtask

    task automatic test_hazard();
        set0(1, 1, 8'h20, 16'h5A5A, 16'h0000);
        set1(1, 0, 8'h20, '0, '0);
        @(negedge CLKIN);
        checks++; if ({REQ0_READY, REQ1_READY, RAM_RE} !== 3'b100) begin errors++; $display("FAIL haz_veto got %b exp 100", {REQ0_READY, REQ1_READY, RAM_RE}); end
        cyc();
        set0(0, 0, '0, '0, '0);
        @(negedge CLKIN);
        checks++; if (REQ1_READY !== 1'b1) begin errors++; $display("FAIL haz_retry got %b exp 1", REQ1_READY); end
        cyc();
        idle();
        @(negedge CLKIN);
        checks++; if (RSP1_VALID !== 1'b1 || RSP1_DATA !== 16'h5A5A) begin errors++; $display("FAIL haz_data got %b/%h exp 1/5a5a", RSP1_VALID, RSP1_DATA); end
        cyc();
    endtask

    task automatic test_fairness();
        logic [DW-1:0] exp_d;
        do_reset();
        set0(1, 1, 8'h40, 16'h1111, '0); cyc();
        set0(1, 1, 8'h50, 16'h2222, '0); cyc();
        set0(1, 0, 8'h40, '0, '0);
        set1(1, 0, 8'h50, '0, '0);
        for (int i = 0; i <= 6; i++) begin
            if (i == 6) idle();
            @(negedge CLKIN);
            if (i < 6) begin
                checks++;
                if ({REQ0_READY, REQ1_READY} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL fair_grant[%0d] got %b exp %b", i, {REQ0_READY, REQ1_READY}, (i % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            if (i > 0) begin
                exp_d = ((i - 1) % 2 == 0) ? 16'h1111 : 16'h2222;
                checks++;
                if ({RSP0_VALID, RSP1_VALID} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01) ||
                    (RSP0_DATA | RSP1_DATA) !== exp_d) begin
                    errors++; $display("FAIL fair_rsp[%0d] got %b/%h exp data %h", i, {RSP0_VALID, RSP1_VALID}, RSP0_DATA | RSP1_DATA, exp_d);
                end
            end
            cyc();
        end
    endtask

    task automatic test_mask();
        set0(1, 1, 8'h70, 16'h0000, 16'h0000); cyc();
        set0(1, 1, 8'h70, 16'hFFFF, 16'hFF00); cyc();
        set0(1, 0, 8'h70, '0, '0); cyc();
        idle();
        @(negedge CLKIN);
        checks++; if (RSP0_VALID !== 1'b1 || RSP0_DATA !== 16'h00FF) begin errors++; $display("FAIL mask_data got %b/%h exp 1/00ff", RSP0_VALID, RSP0_DATA); end
        cyc();
    endtask

    // Randomized traffic on a tiny address window (0xE0..0xE3) so conflicts
    // and hazards are frequent. The model tracks whose turn the next tie is,
    // a plain memory array and the one outstanding response.
    task automatic test_random();
        logic          v[2], we[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2], mk[2];
        logic [DW-1:0] mem [4];
        int            turn;
        logic          pend_v;
        int            pend_who;
        logic [DW-1:0] pend_d;
        logic          gw[2], gr[2];
        int            ww, rw;
        logic          anyw, anyr;
        do_reset();
        turn = 0; pend_v = 0; pend_who = 0; pend_d = '0;
        for (int k = 0; k < 4; k++) mem[k] = '0;
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; we[i] = 0; ad[i] = '0; wd[i] = '0; mk[i] = '0;
        end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i]) begin
                    v[i]  = ($urandom_range(0, 3) != 0);
                    we[i] = $urandom_range(0, 1) == 1;
                    ad[i] = 8'hE0 + 8'($urandom_range(0, 3));
                    wd[i] = 16'($urandom);
                    mk[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
                end
            end
            set0(v[0], we[0], ad[0], wd[0], mk[0]);
            set1(v[1], we[1], ad[1], wd[1], mk[1]);
            anyw = (v[0] && we[0]) || (v[1] && we[1]);
            anyr = (v[0] && !we[0]) || (v[1] && !we[1]);
            ww = (v[0] && we[0] && v[1] && we[1]) ? turn : ((v[1] && we[1]) ? 1 : 0);
            rw = (v[0] && !we[0] && v[1] && !we[1]) ? turn : ((v[1] && !we[1]) ? 1 : 0);
            if (anyw && anyr && ad[ww] == ad[rw]) anyr = 0;
            for (int i = 0; i < 2; i++) begin
                gw[i] = anyw && ww == i;
                gr[i] = anyr && rw == i;
            end
            @(negedge CLKIN);
            checks++;
            if ({REQ0_READY, REQ1_READY} !== {gw[0] || gr[0], gw[1] || gr[1]} || {RAM_WE, RAM_RE} !== {anyw, anyr}) begin
                errors++; $display("FAIL rand_grant[%0d] got rdy %b str %b exp rdy %b str %b", c,
                    {REQ0_READY, REQ1_READY}, {RAM_WE, RAM_RE}, {gw[0] || gr[0], gw[1] || gr[1]}, {anyw, anyr});
            end
            checks++;
            if ({RSP0_VALID, RSP1_VALID} !== {pend_v && pend_who == 0, pend_v && pend_who == 1} ||
                RSP0_DATA !== ((pend_v && pend_who == 0) ? pend_d : 16'h0) ||
                RSP1_DATA !== ((pend_v && pend_who == 1) ? pend_d : 16'h0)) begin
                errors++; $display("FAIL rand_rsp[%0d] got %b %h %h exp v%0b who%0d %h", c,
                    {RSP0_VALID, RSP1_VALID}, RSP0_DATA, RSP1_DATA, pend_v, pend_who, pend_d);
            end
            // Advance the model: tie goes to the other side next time.
            if ((v[0] && we[0] && v[1] && we[1]) || (v[0] && !we[0] && v[1] && !we[1])) begin
                turn = (anyw && v[0] && we[0] && v[1] && we[1]) ? 1 - ww : 1 - rw;
            end
            pend_v = anyr;
            pend_who = rw;
            pend_d = anyr ? mem[ad[rw] - 8'hE0] : '0;
            if (anyw) mem[ad[ww] - 8'hE0] = (mem[ad[ww] - 8'hE0] & mk[ww]) | (wd[ww] & ~mk[ww]);
            for (int i = 0; i < 2; i++) if (gw[i] || gr[i]) v[i] = 0;
            cyc();
        end
        idle();
        cyc();
    endtask

    initial begin
        RESETN = 1'b0;
        idle();
        cyc();
        test_reset();
        test_write_read();
        test_concurrent();
        test_hazard();
        test_fairness();
        test_mask();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
